// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the single-cycle core.
// Owns the PC, sequences start/halt/stall, applies absolute jumps and
// maintains a small LIFO return-address stack for call/return.
module pc_sequencer #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic [PC_W-1:0]                StartAddr,
  input  logic                           Stall,
  input  logic                           Halt,
  input  logic                           Jump,
  input  logic                           Call,
  input  logic                           Ret,
  input  logic [PC_W-1:0]                Target,
  output logic [PC_W-1:0]                PC,
  output logic                           Running,
  output logic                           Done,
  output logic                           StackErr,
  output logic [$clog2(STACK_DEPTH):0]   Depth
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic            push_en;
  logic [PC_W-1:0] stack_q [STACK_DEPTH];

  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic [PC_W-1:0]  pc_inc;

  // Stack pointer counts entries, so the free slot is sp and the top is sp-1.
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign pc_inc   = pc_q + PC_W'(1);

  // Next-state decode: one action per cycle in RUN, resolved by priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          pc_d    = StartAddr;
          sp_d    = '0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_HALTED;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (Ret) begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = ST_HALTED;
          end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - CNT_W'(1);
          end
        end else if (Call) begin
          if (sp_q == CNT_W'(STACK_DEPTH)) begin
            err_d   = 1'b1;
            state_d = ST_HALTED;
          end else begin
            push_en = 1'b1;
            pc_d    = Target;
            sp_d    = sp_q + CNT_W'(1);
          end
        end else if (Jump) begin
          pc_d = Target;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and PC registers; reset returns to IDLE from any state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge Clk) begin
    if (push_en && !Reset) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign PC       = pc_q;
  assign Running  = (state_q == ST_RUN);
  assign Done     = (state_q == ST_HALTED);
  assign StackErr = err_q;
  assign Depth    = sp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run, each checked against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;

  logic            Clk = 1'b0;
  logic            Reset, Start, Stall, Halt, Jump, Call, Ret;
  logic [PC_W-1:0] StartAddr, Target;
  logic [PC_W-1:0] PC;
  logic            Running, Done, StackErr;
  logic [2:0]      Depth;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: 0=idle 1=run 2=halted, stack as a queue.
  int m_state;
  int m_pc;
  bit m_err;
  int m_stack[$];

  wire [15:0] obs = {PC, Running, Done, StackErr, Depth};

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .Jump(Jump), .Call(Call), .Ret(Ret),
    .Target(Target), .PC(PC), .Running(Running), .Done(Done),
    .StackErr(StackErr), .Depth(Depth)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] exp_vec();
    logic [PC_W-1:0] p;
    logic [2:0]      d;
    p = PC_W'(m_pc);
    d = 3'(m_stack.size());
    return {p, m_state == 1, m_state == 2, m_err, d};
  endfunction

  task automatic model_step();
    if (Reset) begin
      m_state = 0; m_pc = 0; m_err = 0; m_stack.delete();
    end else if (m_state != 1) begin
      if (Start) begin
        m_pc = int'(StartAddr); m_stack.delete(); m_err = 0; m_state = 1;
      end
    end else if (Halt) begin
      m_state = 2;
    end else if (Stall) begin
      m_pc = m_pc;
    end else if (Ret) begin
      if (m_stack.size() == 0) begin m_err = 1; m_state = 2; end
      else m_pc = m_stack.pop_back();
    end else if (Call) begin
      if (m_stack.size() == DEPTH) begin m_err = 1; m_state = 2; end
      else begin m_stack.push_back((m_pc + 1) % 1024); m_pc = int'(Target); end
    end else if (Jump) begin
      m_pc = int'(Target);
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
  endtask

  task automatic clear_inputs();
    Reset = 0; Start = 0; Stall = 0; Halt = 0; Jump = 0; Call = 0; Ret = 0;
    StartAddr = '0; Target = '0;
  endtask

  // Advance one clock with the current inputs; sample 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1;
    tick();
    tick();
    n_total++;
    if (obs !== 16'h0000) $display("FAIL reset_state: got %h want %h", obs, 16'h0000);
    else n_pass++;
    Reset = 0;
    Ret = 1;
    tick();
    n_total++;
    if (obs !== exp_vec() || Running !== 1'b0)
      $display("FAIL idle_ignores_ret: got %h want %h", obs, exp_vec());
    else n_pass++;
    Ret = 0;
  endtask

  task automatic test_sequential();
    Start = 1; StartAddr = 10'd15;
    tick();
    Start = 0;
    n_total++;
    if (PC !== 10'd15 || Running !== 1'b1 || obs !== exp_vec())
      $display("FAIL start_pc: got %h want %h", obs, exp_vec());
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_total++;
      if (PC !== 10'(15 + i) || Done !== 1'b0 || obs !== exp_vec())
        $display("FAIL seq_pc%0d: got %0d want %0d", i, PC, 15 + i);
      else n_pass++;
    end
  endtask

  task automatic test_jump();
    Jump = 1; Target = 10'd238;
    tick();
    Jump = 0;
    n_total++;
    if (PC !== 10'd238 || obs !== exp_vec()) $display("FAIL jump_pc: got %0d want 238", PC);
    else n_pass++;
    tick();
    n_total++;
    if (PC !== 10'd239 || obs !== exp_vec()) $display("FAIL jump_next: got %0d want 239", PC);
    else n_pass++;
  endtask

  task automatic test_call_ret();
    Jump = 1; Target = 10'd40;
    tick();
    Jump = 0;
    Call = 1; Target = 10'd335;
    tick();
    Call = 0;
    n_total++;
    if (PC !== 10'd335 || Depth !== 3'd1 || obs !== exp_vec())
      $display("FAIL call_pc: got %h want %h", obs, exp_vec());
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (PC !== 10'd337 || obs !== exp_vec()) $display("FAIL call_body: got %0d want 337", PC);
    else n_pass++;
    Ret = 1;
    tick();
    Ret = 0;
    n_total++;
    if (PC !== 10'd41 || Depth !== 3'd0 || obs !== exp_vec())
      $display("FAIL ret_pc: got %h want %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      Call = 1; Target = 10'($urandom_range(0, 1023));
      tick();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL nested_call%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    Call = 0;
    n_total++;
    if (StackErr !== 1'b1 || Done !== 1'b1 || Depth !== 3'd4)
      $display("FAIL overflow_flags: got err=%b done=%b depth=%0d want 1 1 4", StackErr, Done, Depth);
    else n_pass++;
    Jump = 1; Target = 10'd7;
    tick();
    Jump = 0;
    n_total++;
    if (obs !== exp_vec()) $display("FAIL halted_frozen: got %h want %h", obs, exp_vec());
    else n_pass++;
    Start = 1; StartAddr = 10'd19;
    tick();
    Start = 0;
    n_total++;
    if (PC !== 10'd19 || StackErr !== 1'b0 || Running !== 1'b1 || Depth !== 3'd0 || obs !== exp_vec())
      $display("FAIL restart: got %h want %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_stall_priority();
    Jump = 1; Target = 10'd100;
    tick();
    Stall = 1; Target = 10'd500;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (PC !== 10'd100 || obs !== exp_vec()) $display("FAIL stall%0d: got %0d want 100", i, PC);
      else n_pass++;
    end
    Stall = 0;
    tick();
    Jump = 0;
    n_total++;
    if (PC !== 10'd500 || obs !== exp_vec()) $display("FAIL stall_release: got %0d want 500", PC);
    else n_pass++;
    Call = 1; Halt = 1; Target = 10'd3;
    tick();
    Call = 0; Halt = 0;
    n_total++;
    if (Done !== 1'b1 || PC !== 10'd500 || Depth !== 3'd0 || obs !== exp_vec())
      $display("FAIL halt_call: got %h want %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_wrap_reset();
    Start = 1; StartAddr = 10'd1023;
    tick();
    Start = 0;
    tick();
    n_total++;
    if (PC !== 10'd0 || Running !== 1'b1 || obs !== exp_vec())
      $display("FAIL pc_wrap: got %0d want 0", PC);
    else n_pass++;
    Call = 1; Target = 10'd600;
    tick();
    Reset = 1;
    tick();
    Reset = 0; Call = 0;
    n_total++;
    if (obs !== 16'h0000 || obs !== exp_vec())
      $display("FAIL reset_midrun: got %h want %h", obs, 16'h0000);
    else n_pass++;
    Ret = 1;
    tick();
    Ret = 0;
    n_total++;
    if (obs !== 16'h0000) $display("FAIL ret_in_idle: got %h want %h", obs, 16'h0000);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset     = ($urandom_range(0, 79) == 0);
      Start     = ($urandom_range(0, 7) == 0);
      Halt      = ($urandom_range(0, 24) == 0);
      Stall     = ($urandom_range(0, 5) == 0);
      Ret       = ($urandom_range(0, 4) == 0);
      Call      = ($urandom_range(0, 4) == 0);
      Jump      = ($urandom_range(0, 5) == 0);
      StartAddr = 10'($urandom_range(0, 1023));
      Target    = 10'($urandom_range(0, 1023));
      tick();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    m_state = 0; m_pc = 0; m_err = 0;
    test_reset();
    test_sequential();
    test_jump();
    test_call_ret();
    test_overflow();
    test_stall_priority();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle core; owns the 10-bit PC register that addresses Instruction Memory.
- Sequences program start, halt and stall, and applies absolute jump targets already resolved through the PC target lookup table.
- Adds a small return-address stack so programs can call and return.
- Sits between the instruction decoder (control strobes) and Instruction Memory (PC).

Parameters:
- PC_W, 10, width of PC, StartAddr, Target and stack entries.
- STACK_DEPTH, 4, number of return-address entries (power of 2, at least 2).

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin execution at StartAddr; honoured only in IDLE or HALTED.
- StartAddr  input  PC_W  first instruction address for the selected program.
- Stall  input  1  hold PC this cycle (RUN only).
- Halt  input  1  decoder saw the halt instruction.
- Jump  input  1  absolute jump to Target.
- Call  input  1  push PC+1, then jump to Target.
- Ret  input  1  pop the stack into PC.
- Target  input  PC_W  absolute destination from the PC target LUT.
- PC  output  PC_W  current instruction address.
- Running  output  1  high in RUN.
- Done  output  1  high in HALTED (level, not pulse).
- StackErr  output  1  sticky; set on push-when-full or pop-when-empty.
- Depth  output  clog2(STACK_DEPTH)+1  current number of stack entries.

Behaviour:
- Reset (synchronous, active-high) is honoured in any state, including mid-run:
  - state=IDLE, PC=0, stack pointer=0, Depth=0, StackErr=0, Running=0, Done=0.
  - Stack contents need not be cleared.
- State IDLE:
  - Control strobes other than Start are ignored.
  - Start: PC<=StartAddr, stack pointer cleared, StackErr cleared, next state RUN.
- State RUN: exactly one action per cycle, chosen by priority Halt > Stall > Ret > Call > Jump > sequential.
  - Halt: PC unchanged, next state HALTED.
  - Stall: PC and stack unchanged.
  - Ret with Depth>0: PC<=top entry, Depth decrements.
  - Ret with Depth=0: StackErr<=1, PC unchanged, next state HALTED.
  - Call with Depth<STACK_DEPTH: push PC+1 (mod 2^PC_W), PC<=Target, Depth increments.
  - Call with Depth=STACK_DEPTH: no push, StackErr<=1, PC unchanged, next state HALTED.
  - Jump: PC<=Target.
  - Otherwise: PC<=PC+1, wrapping from 1023 to 0 with no flag.
  - Start is ignored in RUN.
- State HALTED:
  - PC holds; all strobes except Start are ignored.
  - Start behaves exactly as in IDLE (restart), which also clears StackErr.
- Outputs:
  - All outputs are registered or decoded from registered state; no combinational path from any input to any output.
  - Update latency: 1 cycle from strobe to PC change.
- Simultaneous strobes resolve purely by the priority list; for example, Call+Jump executes as Call.
- The stack is LIFO and holds PC_W-bit entries. A push followed by a pop returns the pushed value.

Test Plan:
- Reset, then Start with StartAddr=15, then 5 idle cycles -> PC sequence 15,16,17,18,19,20; Running=1, Done=0.
- In RUN at PC=20, Jump with Target=238 -> next PC=238; following cycle 239.
- At PC=40, Call with Target=335; then 2 sequential cycles; then Ret -> PCs 335,336,337, then 41; Depth goes 1 then 0.
- Five nested Calls with STACK_DEPTH=4 -> first four push (Depth=4); fifth sets StackErr=1, Done=1, PC frozen. Then Start with StartAddr=19 -> PC=19, StackErr=0, Running=1.
- Stall held 3 cycles at PC=100, Jump asserted concurrently -> PC stays 100. Stall released with Jump still high -> PC=Target. Halt+Call in the same cycle -> HALTED, Depth unchanged.
- PC=1023 sequential -> PC=0. Reset asserted mid-RUN with Call active -> PC=0, IDLE, Depth=0. Ret in IDLE -> ignored.
